// File: rtl/alu_pkg.sv
// Shared opcode encoding and sequencer state for the bit-slice ALU sequencer.
package alu_pkg;

    typedef logic [2:0] opsel_t;

    localparam opsel_t OP_AND  = 3'b000;
    localparam opsel_t OP_OR   = 3'b001;
    localparam opsel_t OP_XOR  = 3'b010;
    localparam opsel_t OP_NOT  = 3'b011;
    localparam opsel_t OP_SHL  = 3'b101;
    localparam opsel_t OP_PARK = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic is_legal_op(input opsel_t op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_lane_merge.sv
// Maps one beat of slice outputs to result bits and the carry into the next beat.
module alu_lane_merge
    import alu_pkg::*;
#(
    parameter int LANES = 1
) (
    input  opsel_t           opsel,
    input  logic [LANES-1:0] slice_result,
    input  logic [LANES-1:0] slice_cout,
    input  logic             carry,
    output logic [LANES-1:0] lane_res,
    output logic             carry_next
);

    always_comb begin
        lane_res   = slice_result;
        carry_next = 1'b0;
        if (opsel == OP_SHL) begin
            // Each lane takes the bit shifted out of the lane below; lane 0 takes the beat carry.
            lane_res   = (slice_cout << 1) | LANES'(carry);
            carry_next = slice_cout[LANES-1];
        end
    end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Streams one WIDTH-bit ALU command LSB-first through LANES external 1-bit slices
// and returns the assembled result on a valid/ready response channel.
module alu_slice_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opsel,
    input  logic [WIDTH-1:0] cmd_op1,
    input  logic [WIDTH-1:0] cmd_op2,
    input  logic             cmd_shift_in,
    output logic [2:0]       slice_opsel,
    output logic [LANES-1:0] slice_op1,
    output logic [LANES-1:0] slice_op2,
    input  logic [LANES-1:0] slice_result,
    input  logic [LANES-1:0] slice_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_err
);

    localparam int BEATS = WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    seq_state_t       state;
    opsel_t           opsel_q;
    logic [WIDTH-1:0] op1_q, op2_q, res_q;
    logic [BW-1:0]    beat_q;
    logic             carry_q, cout_q, err_q;
    logic [LANES-1:0] lane_res;
    logic             carry_next;

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign slice_opsel = (state == RUN) ? opsel_q : OP_PARK;
    // Operands shift down each beat so the current lanes always sit in the low bits.
    assign slice_op1   = (state == RUN) ? op1_q[LANES-1:0] : '0;
    assign slice_op2   = (state == RUN) ? op2_q[LANES-1:0] : '0;
    assign rsp_result  = res_q;
    assign rsp_cout    = cout_q;
    assign rsp_err     = err_q;

    alu_lane_merge #(.LANES(LANES)) u_merge (
        .opsel        (opsel_q),
        .slice_result (slice_result),
        .slice_cout   (slice_cout),
        .carry        (carry_q),
        .lane_res     (lane_res),
        .carry_next   (carry_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opsel_q <= OP_PARK;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            beat_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op1_q   <= cmd_op1;
                    op2_q   <= cmd_op2;
                    opsel_q <= cmd_opsel;
                    res_q   <= '0;
                    beat_q  <= '0;
                    carry_q <= cmd_shift_in;
                    cout_q  <= 1'b0;
                    err_q   <= !is_legal_op(cmd_opsel);
                    state   <= is_legal_op(cmd_opsel) ? RUN : RESP;
                end
                RUN: begin
                    op1_q   <= op1_q >> LANES;
                    op2_q   <= op2_q >> LANES;
                    // New lanes enter at the top; after the last beat beat 0 lands at bit 0.
                    res_q   <= (res_q >> LANES) | (WIDTH'(lane_res) << (WIDTH - LANES));
                    carry_q <= carry_next;
                    if (beat_q == LAST_BEAT) begin
                        cout_q <= carry_next;
                        state  <= RESP;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
